// File: rtl/memory_access_unit_pkg.sv
// Shared pipeline definitions: opcode encodings, register-index width,
// the memory-stage FSM state type and opcode classification helpers.
package pipeline_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_SW  = 4'd4;
  localparam logic [3:0] OP_BEQ = 4'd5;
  localparam logic [3:0] OP_BNE = 4'd6;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mau_state_t;

  // Register-file write enable for an opcode. Stores and branches retire
  // without writing; everything else (including unknown opcodes) writes.
  function automatic logic is_wb_op(input logic [3:0] opcode);
    case (opcode)
      OP_SW, OP_BEQ, OP_BNE: return 1'b0;
      default:               return 1'b1;
    endcase
  endfunction

  // True for opcodes that touch data memory.
  function automatic logic is_mem_op(input logic [3:0] opcode);
    return (opcode == OP_LW) || (opcode == OP_SW);
  endfunction

endpackage

// File: rtl/memory_access_unit_if.sv
// Execute -> MEM -> WB bundle. The execute side (master) drives the
// instruction fields and observes stall; the memory stage (slave) drives
// the write-back fields and stall.
interface memory_access_unit_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  import pipeline_pkg::*;

  logic [DATA_W-1:0] alu_result_i;
  logic [REG_W-1:0]  regdest_i;
  logic [ADDR_W-1:0] ldst_i;
  logic [3:0]        instruction_i;
  logic [DATA_W-1:0] wb_data;
  logic [REG_W-1:0]  wb_regdest;
  logic [3:0]        wb_instruction;
  logic              wb_write_en;
  logic              stall;

  modport master (
    output alu_result_i, regdest_i, ldst_i, instruction_i,
    input  wb_data, wb_regdest, wb_instruction, wb_write_en, stall
  );

  modport slave (
    input  alu_result_i, regdest_i, ldst_i, instruction_i,
    output wb_data, wb_regdest, wb_instruction, wb_write_en, stall
  );

endinterface

// File: rtl/memory_access_unit_data_mem.sv
// Data memory: 2**ADDR_W words of DATA_W bits. Synchronous write,
// combinational read, whole array cleared asynchronously by rst.
module data_mem #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clkwire,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port; reset wipes every word so an aborted store leaves no trace.
  always_ff @(posedge clkwire or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read port is combinational so a load sees a store from the previous edge.
  always_comb begin
    rdata = mem[addr];
  end

endmodule

// File: rtl/memory_access_unit.sv
// MEM pipeline stage. Non-memory ops pass straight to write-back in one
// cycle. Loads/stores take MEM_LATENCY cycles; for MEM_LATENCY>1 the
// request is captured into pending registers, stall holds upstream, and
// the access is performed on the final (completion) edge.
module memory_access_unit #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 4,
  parameter int MEM_LATENCY = 1
) (
  input  logic                 clkwire,
  input  logic                 rst,
  memory_access_unit_if.slave  bus
);
  import pipeline_pkg::*;

  localparam int                CNT_W    = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic              MULTI    = (MEM_LATENCY > 1);

  mau_state_t        state;
  logic [CNT_W-1:0]  wait_cnt;

  // Pending request captured at acceptance of a multi-cycle access.
  logic [3:0]        pend_op_p1;
  logic [ADDR_W-1:0] pend_addr_p1;
  logic [DATA_W-1:0] pend_data_p1;
  logic [REG_W-1:0]  pend_rd_p1;

  // Write-back registers.
  logic [DATA_W-1:0] wb_data_p2;
  logic [REG_W-1:0]  wb_rd_p2;
  logic [3:0]        wb_op_p2;
  logic              wb_we_p2;
  logic              stall_q;

  logic              fire_now;
  logic              fire_pend;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Memory port steering: live inputs while idle, pending values while busy.
  always_comb begin
    fire_now  = 1'b0;
    fire_pend = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = bus.ldst_i;
    mem_wdata = bus.alu_result_i;
    if (state == BUSY) begin
      mem_addr  = pend_addr_p1;
      mem_wdata = pend_data_p1;
      fire_pend = (wait_cnt == CNT_ONE);
      mem_we    = fire_pend && (pend_op_p1 == OP_SW);
    end else begin
      fire_now = !MULTI && is_mem_op(bus.instruction_i);
      mem_we   = fire_now && (bus.instruction_i == OP_SW);
    end
  end

  data_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_data_mem (
    .clkwire (clkwire),
    .rst     (rst),
    .we      (mem_we),
    .addr    (mem_addr),
    .wdata   (mem_wdata),
    .rdata   (mem_rdata)
  );

  // Stage FSM, wait counter, pending capture and write-back registers.
  always_ff @(posedge clkwire or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      pend_op_p1   <= '0;
      pend_addr_p1 <= '0;
      pend_data_p1 <= '0;
      pend_rd_p1   <= '0;
      wb_data_p2   <= '0;
      wb_rd_p2     <= '0;
      wb_op_p2     <= '0;
      wb_we_p2     <= 1'b0;
      stall_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (MULTI && is_mem_op(bus.instruction_i)) begin
            pend_op_p1   <= bus.instruction_i;
            pend_addr_p1 <= bus.ldst_i;
            pend_data_p1 <= bus.alu_result_i;
            pend_rd_p1   <= bus.regdest_i;
            wait_cnt     <= CNT_LOAD;
            state        <= BUSY;
            stall_q      <= 1'b1;
            wb_we_p2     <= 1'b0;
            wb_op_p2     <= bus.instruction_i;
          end else begin
            wb_rd_p2 <= bus.regdest_i;
            wb_op_p2 <= bus.instruction_i;
            wb_we_p2 <= is_wb_op(bus.instruction_i);
            if (bus.instruction_i == OP_LW) begin
              wb_data_p2 <= mem_rdata;
            end else begin
              wb_data_p2 <= bus.alu_result_i;
            end
          end
        end
        BUSY: begin
          if (fire_pend) begin
            state    <= IDLE;
            stall_q  <= 1'b0;
            wait_cnt <= '0;
            wb_rd_p2 <= pend_rd_p1;
            wb_op_p2 <= pend_op_p1;
            wb_we_p2 <= is_wb_op(pend_op_p1);
            if (pend_op_p1 == OP_LW) begin
              wb_data_p2 <= mem_rdata;
            end else begin
              wb_data_p2 <= pend_data_p1;
            end
          end else begin
            wait_cnt <= wait_cnt - CNT_ONE;
            wb_we_p2 <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.wb_data        = wb_data_p2;
  assign bus.wb_regdest     = wb_rd_p2;
  assign bus.wb_instruction = wb_op_p2;
  assign bus.wb_write_en    = wb_we_p2;
  assign bus.stall          = stall_q;

endmodule
